mont_exp_ctrl: RTL and testbench



---
 rtl/mont_pkg.sv | 18 +
 rtl/mont_exp_bitsel.sv | 41 ++++
 rtl/mont_exp_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared types and default sizes for the Montgomery exponentiation sequencer.
package mont_pkg;

    localparam int unsigned DEF_NBITS = 256;
    localparam int unsigned DEF_EBITS = 256;
    localparam int unsigned DEF_CNT_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR_ISSUE,
        SQR_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mont_exp_bitsel.sv
// Exponent walker: holds the left-aligned exponent and presents the current bit
// exp_r[idx-1] plus a last-bit flag (idx == 1).
module mont_exp_bitsel
    import mont_pkg::*;
#(
    parameter int unsigned EBITS = DEF_EBITS,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [EBITS-1:0] exp_i,
    input  logic [CNT_W-1:0] bits_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] EBITS_C = CNT_W'(EBITS);

    logic [EBITS-1:0] exp_q;
    logic [CNT_W-1:0] idx_q;

    // The exponent is left-aligned at load so the current bit is always the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            exp_q <= exp_i << (EBITS_C - bits_i);
            idx_q <= bits_i;
        end else if (step_i) begin
            exp_q <= exp_q << 1;
            idx_q <= idx_q - CNT_W'(1);
        end
    end

    assign bit_o  = exp_q[EBITS-1];
    assign last_o = (idx_q == CNT_W'(1));

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Define MONT_EXP_CONST_TIME_EN to issue a multiply for every exponent bit.
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned EBITS = DEF_EBITS,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic [NBITS-1:0] base,
    input  logic [NBITS-1:0] one_mont,
    input  logic [EBITS-1:0] exp,
    input  logic [CNT_W-1:0] exp_bits,
    input  logic [NBITS-1:0] m,
    input  logic [NBITS-1:0] m_size,
    output logic             mul_enable_p,
    output logic [NBITS-1:0] mul_a,
    output logic [NBITS-1:0] mul_b,
    output logic [NBITS-1:0] mul_m,
    output logic [NBITS-1:0] mul_m_size,
    input  logic [NBITS-1:0] mul_y,
    input  logic             mul_done_p,
    output logic [NBITS-1:0] result,
    output logic             busy,
    output logic             done_irq_p,
    output logic [CNT_W:0]   op_count
);

    localparam logic [CNT_W-1:0] EBITS_C = CNT_W'(EBITS);

    state_t           state_q, state_d;
    logic [NBITS-1:0] acc_q, acc_d, base_q, m_q, m_size_q;
    logic [NBITS-1:0] mul_a_q, mul_b_q, result_q;
    logic             mul_en_q, busy_q, done_q;
    logic [CNT_W:0]   op_cnt_q;
    logic [CNT_W-1:0] bits_clamped;
    logic             cur_bit, last_bit, load, step, in_wait, mul_next, take;
    logic             go_sqr, go_mul, go_done;

    assign bits_clamped = (exp_bits > EBITS_C) ? EBITS_C : exp_bits;
    assign load         = (state_q == LOAD);
    assign in_wait      = (state_q == SQR_WAIT) || (state_q == MUL_WAIT);

`ifdef MONT_EXP_CONST_TIME_EN
    // Every bit gets a multiply; a 0-bit product is computed and then dropped.
    assign mul_next = 1'b1;
    assign take     = (state_q == SQR_WAIT) || cur_bit;
`else
    assign mul_next = cur_bit;
    assign take     = 1'b1;
`endif

    assign step = mul_done_p && ((state_q == MUL_WAIT) ||
                                 ((state_q == SQR_WAIT) && !mul_next));

    mont_exp_bitsel #(
        .EBITS (EBITS),
        .CNT_W (CNT_W)
    ) u_bitsel (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .exp_i  (exp),
        .bits_i (bits_clamped),
        .bit_o  (cur_bit),
        .last_o (last_bit)
    );

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = one_mont;
        end else if (in_wait && mul_done_p && take) begin
            acc_d = mul_y;
        end
    end

    always_comb begin
        state_d = state_q;
        go_sqr  = 1'b0;
        go_mul  = 1'b0;
        go_done = 1'b0;
        case (state_q)
            IDLE:      if (start_p) state_d = LOAD;
            LOAD:      if (bits_clamped == '0) go_done = 1'b1; else go_sqr = 1'b1;
            SQR_ISSUE: state_d = SQR_WAIT;
            SQR_WAIT: begin
                if (mul_done_p) begin
                    if (mul_next)      go_mul  = 1'b1;
                    else if (last_bit) go_done = 1'b1;
                    else               go_sqr  = 1'b1;
                end
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done_p) begin
                    if (last_bit) go_done = 1'b1;
                    else          go_sqr  = 1'b1;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (go_sqr)  state_d = SQR_ISSUE;
        if (go_mul)  state_d = MUL_ISSUE;
        if (go_done) state_d = DONE;
    end

    // Outputs are registered on entry to ISSUE/DONE, so operands come from acc_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            m_q      <= '0;
            m_size_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mul_en_q <= go_sqr || go_mul;
            done_q   <= go_done;
            if ((state_q == IDLE) && start_p) begin
                busy_q   <= 1'b1;
                op_cnt_q <= '0;
            end
            if (load) begin
                base_q   <= base;
                m_q      <= m;
                m_size_q <= m_size;
            end
            if (go_sqr) begin
                mul_a_q <= acc_d;
                mul_b_q <= acc_d;
            end
            if (go_mul) begin
                mul_a_q <= acc_d;
                mul_b_q <= base_q;
            end
            if (go_sqr || go_mul) op_cnt_q <= op_cnt_q + (CNT_W+1)'(1);
            if (go_done) begin
                busy_q   <= 1'b0;
                result_q <= acc_d;
            end
        end
    end

    assign mul_enable_p = mul_en_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_m        = m_q;
    assign mul_m_size   = m_size_q;
    assign result       = result_q;
    assign busy         = busy_q;
    assign done_irq_p   = done_q;
    assign op_count     = op_cnt_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl with an R=1 multiplier model (y = a*b mod m, done 3 cycles after enable).
`timescale 1ns/1ps
module tb_mont_exp_ctrl;

    localparam int NB = 256;
    localparam int EB = 256;
    localparam int CW = 9;
`ifdef MONT_EXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_p = 1'b0;
    logic [NB-1:0] base_s = '0, one_s = '0, m_s = '0, msz_s = '0;
    logic [EB-1:0] exp_s = '0;
    logic [CW-1:0] bits_s = '0;
    logic          mul_enable_p, busy, done_irq_p;
    logic [NB-1:0] mul_a, mul_b, mul_m, mul_m_size, mul_y, result;
    logic [CW:0]   op_count;
    logic          model_done, stray_done = 1'b0;
    wire logic     mul_done_p = model_done | stray_done;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.NBITS(NB), .EBITS(EB), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_p      (start_p),
        .base         (base_s),
        .one_mont     (one_s),
        .exp          (exp_s),
        .exp_bits     (bits_s),
        .m            (m_s),
        .m_size       (msz_s),
        .mul_enable_p (mul_enable_p),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_m        (mul_m),
        .mul_m_size   (mul_m_size),
        .mul_y        (mul_y),
        .mul_done_p   (mul_done_p),
        .result       (result),
        .busy         (busy),
        .done_irq_p   (done_irq_p),
        .op_count     (op_count)
    );

    // Multiplier model; also counts operand changes while a multiply is in flight.
    logic [NB-1:0] ma, mb, mm;
    int            mcnt;
    int            hold_err = 0;

    function automatic logic [NB-1:0] mulmod(input logic [NB-1:0] a, b, md);
        logic [2*NB-1:0] p;
        if (md == '0) return '0;
        p = {{NB{1'b0}}, a} * {{NB{1'b0}}, b};
        p = p % {{NB{1'b0}}, md};
        return p[NB-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt       <= 0;
            model_done <= 1'b0;
            mul_y      <= '0;
        end else begin
            model_done <= 1'b0;
            if (mul_enable_p) begin
                ma   <= mul_a;
                mb   <= mul_b;
                mm   <= mul_m;
                mcnt <= 2;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mul_a !== ma || mul_b !== mb || mul_m !== mm) hold_err++;
                if (mcnt == 1) begin
                    model_done <= 1'b1;
                    mul_y      <= mulmod(ma, mb, mm);
                end
            end
        end
    end

    int done_cnt = 0, en_cnt = 0;
    always @(negedge clk) begin
        if (done_irq_p === 1'b1) done_cnt++;
        if (mul_enable_p === 1'b1) en_cnt++;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic longint unsigned powmod(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned md);
        longint unsigned r = 1 % md;
        longint unsigned x = b % md;
        longint unsigned k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % md;
            x = (x * x) % md;
            k = k >> 1;
        end
        return r;
    endfunction

    typedef struct {
        logic [NB-1:0] base, one, m, res;
        logic [EB-1:0] e;
        int            bits, msz, ops, ops_ct;
    } vec_t;

    task automatic run(input vec_t v, input int restart_at, input bit scramble, input string tag);
        int d0, e0, h0, lat, ops, budget, mbad;
        d0 = done_cnt; e0 = en_cnt; h0 = hold_err; lat = -1; mbad = 0;
        ops    = CT ? v.ops_ct : v.ops;
        budget = 2 + 4 * ops + 20;
        base_s = v.base; one_s = v.one; exp_s = v.e; bits_s = v.bits[CW-1:0];
        m_s = v.m; msz_s = NB'(v.msz);
        start_p = 1'b1;
        for (int cyc = 1; cyc <= budget && lat < 0; cyc++) begin
            @(posedge clk); #1;
            start_p = (cyc == restart_at);
            if (cyc == restart_at) base_s = NB'(6);
            if (scramble && cyc >= 2) begin
                base_s = {8{$urandom}}; m_s = {8{$urandom}}; one_s = {8{$urandom}};
                exp_s = {8{$urandom}}; bits_s = CW'($urandom); msz_s = {8{$urandom}};
            end
            if (scramble && cyc >= 2 && busy && mul_m !== v.m) mbad++;
            if (done_irq_p === 1'b1) lat = cyc;
        end
        chk({tag, " latency"}, NB'(lat), NB'(2 + 4 * ops));
        chk({tag, " result"}, result, v.res);
        chk({tag, " op_count"}, NB'(op_count), NB'(ops));
        chk({tag, " busy@done"}, NB'(busy), NB'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " done pulses"}, NB'(done_cnt - d0), NB'(1));
        chk({tag, " enable pulses"}, NB'(en_cnt - e0), NB'(ops));
        chk({tag, " operand hold"}, NB'(hold_err - h0), NB'(0));
        chk({tag, " result held"}, result, v.res);
        if (ops != 0) chk({tag, " mul_m_size"}, mul_m_size, NB'(v.msz));
        if (scramble) chk({tag, " mul_m stable"}, NB'(mbad), NB'(0));
    endtask

    vec_t vt[9];
    vec_t v0;
    int   d0;

    initial begin
        vt[0] = '{base:3, one:1, m:7, res:5, e:5, bits:3, msz:3, ops:5, ops_ct:6};
        vt[1] = '{base:3, one:1, m:7, res:1, e:5, bits:0, msz:3, ops:0, ops_ct:0};
        vt[2] = '{base:2, one:1, m:1000003, res:NB'(powmod(2, 255, 1000003)), e:'hFF, bits:8,
                  msz:20, ops:16, ops_ct:16};
        vt[3] = '{base:7, one:1, m:101, res:NB'(powmod(7, 27, 101)), e:27, bits:5, msz:7,
                  ops:9, ops_ct:10};
        vt[4] = '{base:4, one:1, m:11, res:4, e:13, bits:2, msz:4, ops:3, ops_ct:4};
        vt[5] = '{base:6, one:1, m:13, res:6, e:1, bits:1, msz:4, ops:2, ops_ct:2};
        vt[6] = '{base:5, one:1, m:13, res:1, e:0, bits:4, msz:4, ops:4, ops_ct:8};
        vt[7] = '{base:9, one:9, m:13, res:9, e:5, bits:0, msz:4, ops:0, ops_ct:0};
        // exp_bits above EBITS clamps to 256 bits; exponent 2^255+5, 3 has order 6 mod 7.
        vt[8] = '{base:3, one:1, m:7, res:3, e:5, bits:300, msz:3, ops:259, ops_ct:512};
        vt[8].e[EB-1] = 1'b1;

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", NB'(busy), NB'(0));
        chk("reset mul_enable_p", NB'(mul_enable_p), NB'(0));
        chk("reset done_irq_p", NB'(done_irq_p), NB'(0));
        chk("reset result", result, '0);
        chk("reset op_count", NB'(op_count), '0);
        chk("reset mul_a", mul_a, '0);
        chk("reset mul_m", mul_m, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run(vt[i], 0, 1'b0, $sformatf("vec%0d", i));

        d0 = done_cnt;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray done busy", NB'(busy), NB'(0));
        chk("stray done irq", NB'(done_cnt - d0), NB'(0));
        chk("stray done result", result, vt[8].res);

        run(vt[0], 4, 1'b0, "restart");
        run(vt[0], 0, 1'b1, "scramble");

        v0 = vt[0];
        base_s = v0.base; one_s = v0.one; exp_s = v0.e; bits_s = CW'(3); m_s = v0.m; msz_s = NB'(3);
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-reset busy", NB'(busy), NB'(1));
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrun busy", NB'(busy), NB'(0));
        chk("midrun result", result, '0);
        chk("midrun op_count", NB'(op_count), '0);
        chk("midrun mul_a", mul_a, '0);
        chk("midrun mul_b", mul_b, '0);
        chk("midrun mul_m", mul_m, '0);
        chk("midrun mul_m_size", mul_m_size, '0);
        chk("midrun enable", NB'(mul_enable_p), NB'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no irq after reset", NB'(done_cnt - d0), NB'(0));
        run(vt[0], 0, 1'b0, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
